// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_t;

   localparam int          PC_STEP   = 4;
   localparam logic [31:0] INSTR_NOP = 32'h00000013;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with increment, redirect load and alignment handling
// Optional: FETCH_ALIGN_CHECK_EN rejects misaligned loads instead of masking the low bits.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc_en,
   input  logic                load_en,
   input  logic [PC_WIDTH-1:0] load_pc,
   output logic                load_ok,
   output logic [PC_WIDTH-1:0] pc
);

   logic [PC_WIDTH-1:0] load_aligned;

   assign load_aligned = load_pc & ~PC_WIDTH'(3);

`ifdef FETCH_ALIGN_CHECK_EN
   assign load_ok = (load_aligned == load_pc);
`else
   assign load_ok = 1'b1;
`endif

   // Increment wraps modulo 2^PC_WIDTH; a redirect load always wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (load_en && load_ok) begin
         pc <= load_aligned;
      end else if (inc_en) begin
         pc <= pc + PC_WIDTH'(PC_STEP);
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding instruction fetch sequencer between PC/imem and decode
// Optional: FETCH_ALIGN_CHECK_EN adds misalign_err and ignores misaligned redirects.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int                  PC_WIDTH    = 16,
   parameter int                  INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
   output logic                   if_valid,
   input  logic                   if_ready,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic [PC_WIDTH-1:0]    if_pc,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic                   misalign_err
`endif
);

   fetch_state_t        state, state_nxt;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] req_pc;
   logic                redirect_ok;
   logic                redirect_eff;
   logic                req_fire;
   logic                capture;
   logic                flush;

   assign req_fire     = (state == REQ) && imem_req_ready;
   assign redirect_eff = redirect_valid && redirect_ok;

   fetch_pc_reg #(
      .PC_WIDTH (PC_WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk     (clk),
      .rst     (rst),
      .inc_en  (req_fire && !redirect_eff),
      .load_en (redirect_eff),
      .load_pc (redirect_pc),
      .load_ok (redirect_ok),
      .pc      (pc)
   );

   assign imem_req_valid = (state == REQ);
   assign imem_addr      = pc;
   assign if_valid       = (state == HOLD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Redirect outranks every other event; an accepted request it overtakes is drained.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      flush     = 1'b0;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            if (imem_req_ready) begin
               state_nxt = redirect_eff ? DRAIN : WAIT;
            end
         end
         WAIT: begin
            if (redirect_eff) begin
               state_nxt = imem_rsp_valid ? REQ : DRAIN;
            end else if (imem_rsp_valid) begin
               state_nxt = HOLD;
               capture   = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_eff) begin
               state_nxt = REQ;
               flush     = 1'b1;
            end else if (if_ready) begin
               state_nxt = REQ;
            end
         end
         DRAIN: begin
            if (!redirect_eff && imem_rsp_valid) begin
               state_nxt = REQ;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_pc   <= '0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         if (req_fire) begin
            req_pc <= pc;
         end
         if (capture) begin
            if_instr <= imem_rsp_data;
            if_pc    <= req_pc;
         end else if (flush) begin
            if_instr <= INSTR_WIDTH'(INSTR_NOP);
         end
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         misalign_err <= 1'b0;
      end else if (redirect_valid && !redirect_ok) begin
         misalign_err <= 1'b1;
      end
   end
`endif

endmodule
